pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32IM pipeline. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes, data-memory wait states and the multi-cycle divider, which it starts and times with an internal counter. It also keeps a free-running count of front-end stall cycles for performance analysis.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/pipeline_ctrl_if.sv | 51 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 27 ++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pkg : shared pipeline-control types and constants                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package riscv_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_ctrl_if : hazard inputs and stage controls of the 5-stage core  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pipeline_ctrl_if;
    import riscv_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_is_div;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  dmem_ready;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mem_wb_flush;
    logic                  div_start;
    logic                  div_done;
    logic [31:0]           stall_cycles;

    // Pipeline datapath side: reports hazards, consumes controls
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_is_div, ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               div_start, div_done, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_is_div, ex_branch_taken, mem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               div_start, div_done, stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_detect : load-use comparator between ID sources and EX load dest  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load to it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_ctrl : stall/flush sequencer with divider timing and stall count|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus
);

    localparam int               CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_q, stall_d;

    logic load_use;
    logic mst;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic div_start, div_done;

    hazard_detect u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (load_use)
    );

    assign mst = bus.mem_req && !bus.dmem_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        div_start    = 1'b0;
        div_done     = 1'b0;

        if (mst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (!mst) begin
                    if (bus.ex_is_div) begin
                        div_start    = 1'b1;
                        state_d      = DIV_WAIT;
                        cnt_d        = CNT_LOAD;
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (bus.ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            DIV_WAIT: begin
                if (cnt_q != '0) begin
                    // The divider keeps running underneath a memory stall
                    cnt_d = cnt_q - 1'b1;
                    if (!mst) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end else begin
                    div_done = 1'b1;
                    if (!mst) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        stall_d = pc_en ? stall_q : stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // A flush forces its register to load; reset silences every control
    assign bus.pc_en        = rst_n & pc_en;
    assign bus.if_id_en     = rst_n & (if_id_en  | if_id_flush);
    assign bus.id_ex_en     = rst_n & (id_ex_en  | id_ex_flush);
    assign bus.ex_mem_en    = rst_n & (ex_mem_en | ex_mem_flush);
    assign bus.mem_wb_en    = rst_n & (mem_wb_en | mem_wb_flush);
    assign bus.if_id_flush  = rst_n & if_id_flush;
    assign bus.id_ex_flush  = rst_n & id_ex_flush;
    assign bus.ex_mem_flush = rst_n & ex_mem_flush;
    assign bus.mem_wb_flush = rst_n & mem_wb_flush;
    assign bus.div_start    = rst_n & div_start;
    assign bus.div_done     = rst_n & div_done;
    assign bus.stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_ctrl : directed self-checking bench for pipeline_ctrl        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipeline_ctrl;

    // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb flush | start,done}
    localparam logic [10:0] C_ZERO   = 11'b00000_0000_00;
    localparam logic [10:0] C_NORM   = 11'b11111_0000_00;
    localparam logic [10:0] C_LDUSE  = 11'b00111_0100_00;
    localparam logic [10:0] C_BRANCH = 11'b11111_1100_00;
    localparam logic [10:0] C_DSTART = 11'b00011_0010_10;
    localparam logic [10:0] C_DFRZ   = 11'b00011_0010_00;
    localparam logic [10:0] C_DDONE  = 11'b11111_0000_01;
    localparam logic [10:0] C_MST    = 11'b00001_0001_00;
    localparam logic [10:0] C_MSTDN  = 11'b00001_0001_01;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    logic [31:0] s0;
    logic [10:0] ctl;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.DIV_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                  bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                  bus.div_start, bus.div_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_rd           = '0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_is_div       = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.dmem_ready      = 1'b1;
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 2 ns later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        bus.ex_is_div = 1'b1;
        bus.mem_req   = 1'b1;
        bus.dmem_ready = 1'b0;
        next_cycle();
        #2;
        checks++;
        if (ctl !== C_ZERO) begin
            failures++;
            $display("FAIL reset_outputs ctl=%b exp=%b", ctl, C_ZERO);
        end
        checks++;
        if (bus.stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles);
        end
        next_cycle();
        set_idle();
        rst_n = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            failures++;
            $display("FAIL reset_release ctl=%b exp=%b", ctl, C_NORM);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        s0 = bus.stall_cycles;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
        #2;
        checks++;
        if (ctl !== C_LDUSE) begin
            failures++;
            $display("FAIL load_use_rs1 ctl=%b exp=%b", ctl, C_LDUSE);
        end
        next_cycle();
        set_idle();
        #2;
        checks++;
        if (ctl !== C_NORM || bus.stall_cycles !== s0 + 32'd1) begin
            failures++;
            $display("FAIL load_use_bubble ctl=%b exp=%b stall=%0d exp=%0d",
                     ctl, C_NORM, bus.stall_cycles, s0 + 32'd1);
        end
        next_cycle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            failures++;
            $display("FAIL load_use_x0 ctl=%b exp=%b", ctl, C_NORM);
        end
        next_cycle();
        set_idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
        #2;
        checks++;
        if (ctl !== C_LDUSE) begin
            failures++;
            $display("FAIL load_use_rs2 ctl=%b exp=%b", ctl, C_LDUSE);
        end
        next_cycle();
        set_idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b0;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            failures++;
            $display("FAIL load_use_unused ctl=%b exp=%b", ctl, C_NORM);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_branch();
        s0 = bus.stall_cycles;
        bus.ex_branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BRANCH) begin
            failures++;
            $display("FAIL branch_flush ctl=%b exp=%b", ctl, C_BRANCH);
        end
        next_cycle();
        set_idle();
        #2;
        checks++;
        if (ctl !== C_NORM || bus.stall_cycles !== s0) begin
            failures++;
            $display("FAIL branch_after ctl=%b exp=%b stall=%0d exp=%0d",
                     ctl, C_NORM, bus.stall_cycles, s0);
        end
    endtask

    task automatic test_mem_stall();
        next_cycle();
        s0 = bus.stall_cycles;
        bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
        bus.ex_branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl !== C_MST) begin
            failures++;
            $display("FAIL mst_run ctl=%b exp=%b", ctl, C_MST);
        end
        next_cycle();
        bus.dmem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BRANCH || bus.stall_cycles !== s0 + 32'd1) begin
            failures++;
            $display("FAIL mst_release ctl=%b exp=%b stall=%0d exp=%0d",
                     ctl, C_BRANCH, bus.stall_cycles, s0 + 32'd1);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_divide();
        next_cycle();
        s0 = bus.stall_cycles;
        bus.ex_is_div = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [10:0] exp_ctl;
            exp_ctl = (i == 0) ? C_DSTART : (i == 4) ? C_DDONE : C_DFRZ;
            #2;
            checks++;
            if (ctl !== exp_ctl) begin
                failures++;
                $display("FAIL divide_cycle%0d ctl=%b exp=%b", i, ctl, exp_ctl);
            end
            next_cycle();
        end
        bus.ex_is_div = 1'b0;
        #2;
        checks++;
        if (ctl !== C_NORM || bus.stall_cycles !== s0 + 32'd4) begin
            failures++;
            $display("FAIL divide_after ctl=%b exp=%b stall=%0d exp=%0d",
                     ctl, C_NORM, bus.stall_cycles, s0 + 32'd4);
        end
    endtask

    task automatic test_mem_in_div();
        next_cycle();
        s0 = bus.stall_cycles;
        bus.ex_is_div = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl !== C_MSTDN) begin
                failures++;
                $display("FAIL div_mst_hold%0d ctl=%b exp=%b", i, ctl, C_MSTDN);
            end
            next_cycle();
        end
        bus.dmem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_DDONE) begin
            failures++;
            $display("FAIL div_mst_release ctl=%b exp=%b", ctl, C_DDONE);
        end
        next_cycle();
        set_idle();
        #2;
        checks++;
        if (ctl !== C_NORM || bus.stall_cycles !== s0 + 32'd7) begin
            failures++;
            $display("FAIL div_mst_after ctl=%b exp=%b stall=%0d exp=%0d",
                     ctl, C_NORM, bus.stall_cycles, s0 + 32'd7);
        end
    endtask

    task automatic test_reset_mid_div();
        next_cycle();
        bus.ex_is_div = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (ctl !== C_ZERO || bus.stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL mid_div_reset ctl=%b exp=%b stall=%0d exp=0",
                     ctl, C_ZERO, bus.stall_cycles);
        end
        next_cycle();
        set_idle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (ctl !== C_NORM || bus.stall_cycles !== 32'd0) begin
                failures++;
                $display("FAIL mid_div_after%0d ctl=%b exp=%b stall=%0d exp=0",
                         i, ctl, C_NORM, bus.stall_cycles);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        bus.ex_is_div = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [10:0] exp_ctl;
            exp_ctl = (i % 5 == 0) ? C_DSTART : (i % 5 == 4) ? C_DDONE : C_DFRZ;
            #2;
            checks++;
            if (ctl !== exp_ctl) begin
                failures++;
                $display("FAIL b2b_cycle%0d ctl=%b exp=%b", i, ctl, exp_ctl);
            end
            next_cycle();
        end
        set_idle();
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            failures++;
            $display("FAIL b2b_after ctl=%b exp=%b", ctl, C_NORM);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_divide();
        test_mem_in_div();
        test_reset_mid_div();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
